// File: rtl/serving_sram_arb_pkg.sv
// rtl/serving_sram_arb_pkg.sv - shared widths and byte-lane helper for the serving SRAM arbiter
package serving_sram_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int N_LANES = 4;

    typedef logic [1:0] lane_t;

    // Little-endian byte lane k of a 32-bit word.
    function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] w, input lane_t k);
        return w[BYTE_W*k +: BYTE_W];
    endfunction

endpackage

// File: rtl/serving_sram_arb_if.sv
// rtl/serving_sram_arb_if.sv - primary, secondary and SRAM-side signals of the arbiter
interface serving_sram_arb_if
    import serving_sram_arb_pkg::*;
#(
    parameter int AW = 13
);
    logic [AW-1:0]      i_p_waddr;
    logic [BYTE_W-1:0]  i_p_wdata;
    logic               i_p_wen;
    logic [AW-1:0]      i_p_raddr;
    logic               i_p_ren;
    logic [BYTE_W-1:0]  o_p_rdata;

    logic [AW-3:0]      i_s_adr;
    logic [WORD_W-1:0]  i_s_dat;
    logic [N_LANES-1:0] i_s_sel;
    logic               i_s_we;
    logic               i_s_stb;
    logic [WORD_W-1:0]  o_s_rdt;
    logic               o_s_ack;

    logic [AW-1:0]      o_sram_waddr;
    logic [BYTE_W-1:0]  o_sram_wdata;
    logic               o_sram_wen;
    logic [AW-1:0]      o_sram_raddr;
    logic [BYTE_W-1:0]  i_sram_rdata;

    modport slave (
        input  i_p_waddr, i_p_wdata, i_p_wen, i_p_raddr, i_p_ren,
        output o_p_rdata,
        input  i_s_adr, i_s_dat, i_s_sel, i_s_we, i_s_stb,
        output o_s_rdt, o_s_ack,
        output o_sram_waddr, o_sram_wdata, o_sram_wen, o_sram_raddr,
        input  i_sram_rdata
    );

    modport master (
        output i_p_waddr, i_p_wdata, i_p_wen, i_p_raddr, i_p_ren,
        input  o_p_rdata,
        output i_s_adr, i_s_dat, i_s_sel, i_s_we, i_s_stb,
        input  o_s_rdt, o_s_ack,
        input  o_sram_waddr, o_sram_wdata, o_sram_wen, o_sram_raddr,
        output i_sram_rdata
    );

endinterface

// File: rtl/serving_sram_arb.sv
// rtl/serving_sram_arb.sv - shares the byte-wide SRAM between the RF port and a 32-bit secondary port
module serving_sram_arb
    import serving_sram_arb_pkg::*;
#(
    parameter int depth    = 8192,
    parameter int rf_width = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    serving_sram_arb_if.slave bus
);

    localparam int aw = $clog2(depth);
    localparam int LW = rf_width;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    logic [2:0]         state_q, state_d;
    lane_t              idx_q, idx_d;
    logic [aw-3:0]      adr_q, adr_d;
    logic [WORD_W-1:0]  dat_q, dat_d;
    logic [N_LANES-1:0] sel_q, sel_d;
    logic               cap_vld_q, cap_vld_d;
    lane_t              cap_idx_q, cap_idx_d;
    logic [WORD_W-1:0]  rdt_q, rdt_d;

    logic free;
    logic issue_w;
    logic issue_r;

    // The secondary only gets cycles the primary leaves idle; nothing is issued while reset is held
    // so an interrupted write never lands an extra lane.
    assign free    = !bus.i_p_wen && !bus.i_p_ren;
    assign issue_w = (state_q == S_WRITE) && free && !i_rst;
    assign issue_r = (state_q == S_READ) && free && !i_rst;

    assign bus.o_p_rdata = bus.i_sram_rdata;
    assign bus.o_s_ack   = (state_q == S_ACK);
    assign bus.o_s_rdt   = rdt_q;

    // SRAM port mux: primary passes through unless the secondary owns this idle cycle.
    always_comb begin
        bus.o_sram_waddr = bus.i_p_waddr;
        bus.o_sram_wdata = bus.i_p_wdata;
        bus.o_sram_wen   = bus.i_p_wen;
        bus.o_sram_raddr = bus.i_p_raddr;
        if (issue_w) begin
            bus.o_sram_waddr = {adr_q, idx_q};
            bus.o_sram_wdata = lane_byte(dat_q, idx_q);
            bus.o_sram_wen   = sel_q[idx_q];
        end
        if (issue_r) begin
            bus.o_sram_raddr = {adr_q, idx_q};
        end
    end

    // Transaction sequencing: accept, issue four lanes in free cycles, drain the last read, ack once.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cap_vld_d = issue_r;
        cap_idx_d = idx_q;
        rdt_d     = rdt_q;
        if (cap_vld_q) begin
            rdt_d[LW*cap_idx_q +: LW] = bus.i_sram_rdata;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.i_s_stb) begin
                    adr_d   = bus.i_s_adr;
                    dat_d   = bus.i_s_dat;
                    sel_d   = bus.i_s_sel;
                    idx_d   = 2'd0;
                    state_d = bus.i_s_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (issue_w) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_ACK;
                end
            end
            S_READ: begin
                if (issue_r) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_vld_q && cap_idx_q == 2'd3) state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction without an ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 2'd0;
            rdt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            rdt_q     <= rdt_d;
        end
    end

endmodule

// File: tb/tb_serving_sram_arb.sv
// tb/tb_serving_sram_arb.sv - self-checking bench for serving_sram_arb
module tb_serving_sram_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serving_sram_arb_if #(.AW(13)) bus ();

    serving_sram_arb #(.depth(8192), .rf_width(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [7:0] mem [0:8191] = '{default: 8'h00};

    // Registered-read SRAM.
    always @(posedge clk) begin
        if (bus.o_sram_wen) mem[bus.o_sram_waddr] <= bus.o_sram_wdata;
        bus.i_sram_rdata <= mem[bus.o_sram_raddr];
    end

    typedef struct {
        logic        we;
        logic [10:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          pmode;
        logic [31:0] exp_rdt;
        int          exp_lat;
        int          exp_wens;
    } vec_t;

    vec_t vecs [0:11];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Primary pattern for cycle n of a transaction.
    task automatic set_prim(input int mode, input int n);
        bus.i_p_wen   = 1'b0;
        bus.i_p_ren   = 1'b0;
        bus.i_p_waddr = '0;
        bus.i_p_wdata = '0;
        bus.i_p_raddr = '0;
        if (mode == 1 && n >= 1 && n <= 7 && (n % 2) == 1) begin
            if ((n % 4) == 1) begin
                bus.i_p_ren   = 1'b1;
                bus.i_p_raddr = 13'h100;
            end else begin
                bus.i_p_wen   = 1'b1;
                bus.i_p_waddr = 13'h300 + 13'(n);
                bus.i_p_wdata = 8'(n);
            end
        end
        if (mode == 2 && n >= 1 && n <= 20) begin
            bus.i_p_ren   = 1'b1;
            bus.i_p_raddr = 13'h100 + 13'(n);
        end
    endtask

    task automatic prim_checks();
        if (bus.i_p_ren) check("p_raddr_pass", 32'(bus.o_sram_raddr), 32'(bus.i_p_raddr));
        if (bus.i_p_wen) begin
            check("p_wen_pass", 32'(bus.o_sram_wen), 32'd1);
            check("p_waddr_pass", 32'(bus.o_sram_waddr), 32'(bus.i_p_waddr));
            check("p_wdata_pass", 32'(bus.o_sram_wdata), 32'(bus.i_p_wdata));
        end
    endtask

    task automatic sec_xfer(input vec_t v, output int lat, output int wens, output logic [31:0] rdt);
        logic prev_ren100;
        lat  = -1;
        wens = 0;
        rdt  = 'x;
        @(negedge clk);
        bus.i_s_stb = 1'b1;
        bus.i_s_we  = v.we;
        bus.i_s_adr = v.adr;
        bus.i_s_dat = v.dat;
        bus.i_s_sel = v.sel;
        set_prim(v.pmode, 0);
        #1;
        prev_ren100 = bus.i_p_ren && bus.i_p_raddr == 13'h100;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            bus.i_s_stb = 1'b0;
            set_prim(v.pmode, n);
            #1;
            prim_checks();
            if (prev_ren100 && v.pmode == 1) check("p_rdata", 32'(bus.o_p_rdata), 32'h5C);
            prev_ren100 = bus.i_p_ren && bus.i_p_raddr == 13'h100;
            if (bus.o_sram_wen && !bus.i_p_wen) wens++;
            if (bus.o_s_ack) begin
                lat = n;
                rdt = bus.o_s_rdt;
                break;
            end
        end
        if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        set_prim(0, 0);
        #1;
        check("ack_width", 32'(bus.o_s_ack), 32'd0);
    endtask

    initial begin
        int          lat, wens, a1, a2, ack_seen;
        logic [31:0] rdt;
        vec_t        v;

        vecs[0]  = '{1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, 5, 4};
        vecs[1]  = '{1'b0, 11'h010, 32'h00000000, 4'hF, 0, 32'hDEADBEEF, 6, 0};
        vecs[2]  = '{1'b1, 11'h020, 32'hFFFFFFFF, 4'hF, 0, 32'hDEADBEEF, 5, 4};
        vecs[3]  = '{1'b1, 11'h020, 32'h11223344, 4'h5, 0, 32'hDEADBEEF, 5, 2};
        vecs[4]  = '{1'b0, 11'h020, 32'h00000000, 4'hF, 0, 32'hFF22FF44, 6, 0};
        vecs[5]  = '{1'b0, 11'h010, 32'h00000000, 4'h0, 0, 32'hDEADBEEF, 6, 0};
        vecs[6]  = '{1'b1, 11'h040, 32'h0000005C, 4'h1, 0, 32'hDEADBEEF, 5, 1};
        vecs[7]  = '{1'b0, 11'h020, 32'h00000000, 4'hF, 1, 32'hFF22FF44, 10, 0};
        vecs[8]  = '{1'b1, 11'h030, 32'h01020304, 4'hF, 2, 32'hFF22FF44, 25, 4};
        vecs[9]  = '{1'b0, 11'h030, 32'h00000000, 4'hF, 0, 32'h01020304, 6, 0};
        vecs[10] = '{1'b1, 11'h7FF, 32'hA5A55A5A, 4'hF, 0, 32'h01020304, 5, 4};
        vecs[11] = '{1'b0, 11'h7FF, 32'h00000000, 4'hF, 0, 32'hA5A55A5A, 6, 0};

        rst = 1'b1;
        bus.i_s_stb = 1'b0;
        bus.i_s_we  = 1'b0;
        bus.i_s_adr = '0;
        bus.i_s_dat = '0;
        bus.i_s_sel = '0;
        set_prim(0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(bus.o_s_ack), 32'd0);
        check("rst_rdt", bus.o_s_rdt, 32'd0);
        bus.i_p_wen   = 1'b1;
        bus.i_p_waddr = 13'h123;
        bus.i_p_wdata = 8'h77;
        #1;
        check("rst_wen_follow1", 32'(bus.o_sram_wen), 32'd1);
        check("rst_waddr_follow", 32'(bus.o_sram_waddr), 32'h123);
        bus.i_p_wen = 1'b0;
        #1;
        check("rst_wen_follow0", 32'(bus.o_sram_wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 11; i++) begin
            v = vecs[i];
            sec_xfer(v, lat, wens, rdt);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("v%0d_wens", i), 32'(wens), 32'(v.exp_wens));
            check($sformatf("v%0d_rdt", i), rdt, v.exp_rdt);
            if (i == 0) begin
                check("mem40", 32'(mem[13'h40]), 32'hEF);
                check("mem41", 32'(mem[13'h41]), 32'hBE);
                check("mem42", 32'(mem[13'h42]), 32'hAD);
                check("mem43", 32'(mem[13'h43]), 32'hDE);
            end
            if (i == 7) begin
                check("p_write_303", 32'(mem[13'h303]), 32'h03);
                check("p_write_307", 32'(mem[13'h307]), 32'h07);
            end
        end

        // Reset after two lanes of a write.
        @(negedge clk);
        bus.i_s_stb = 1'b1;
        bus.i_s_we  = 1'b1;
        bus.i_s_adr = 11'h050;
        bus.i_s_dat = 32'h99887766;
        bus.i_s_sel = 4'hF;
        @(negedge clk);
        bus.i_s_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rdt", bus.o_s_rdt, 32'd0);
        ack_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            #1;
            if (bus.o_s_ack) ack_seen = 1;
        end
        check("midrst_no_ack", 32'(ack_seen), 32'd0);
        check("midrst_b0", 32'(mem[13'h140]), 32'h66);
        check("midrst_b1", 32'(mem[13'h141]), 32'h77);
        check("midrst_b2", 32'(mem[13'h142]), 32'h00);
        check("midrst_b3", 32'(mem[13'h143]), 32'h00);
        v = '{1'b0, 11'h050, 32'h0, 4'hF, 0, 32'h00007766, 6, 0};
        sec_xfer(v, lat, wens, rdt);
        check("postrst_lat", 32'(lat), 32'd6);
        check("postrst_rdt", rdt, 32'h00007766);

        // Back-to-back with stb held through the ack.
        @(negedge clk);
        bus.i_s_stb = 1'b1;
        bus.i_s_we  = 1'b1;
        bus.i_s_adr = 11'h060;
        bus.i_s_dat = 32'h0BADF00D;
        bus.i_s_sel = 4'hF;
        a1 = -1;
        a2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (bus.o_s_ack) begin
                if (a1 < 0) begin
                    a1 = n;
                    bus.i_s_we = 1'b0;
                end else begin
                    a2 = n;
                    rdt = bus.o_s_rdt;
                    bus.i_s_stb = 1'b0;
                    break;
                end
            end
        end
        check("b2b_ack1", 32'(a1), 32'd5);
        check("b2b_ack2", 32'(a2), 32'd12);
        check("b2b_rdt", rdt, 32'h0BADF00D);
        ack_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            #1;
            if (bus.o_s_ack) ack_seen = 1;
        end
        check("b2b_no_extra_ack", 32'(ack_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
